branch_control_unit: RTL and testbench

Multicycle control sequencer that drives the branch-decision datapath. It runs instruction fetch and decode, then executes conditional branches (BEQ/BNE/BLT/BGE), JAL and JALR itself. For branches it produces `PcWriteCond`, `BranchType` and the ALU compare setup that the branch selector turns into a conditional PC write. Every other opcode is handed to the rest of the control unit through a start/done handshake, and control returns to fetch when that unit finishes.

---
 rtl/branch_control_unit.sv | 140 ++++++++++++++
 tb/tb_branch_control_unit.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/branch_control_unit.sv
// rtl/branch_control_unit.sv - multicycle fetch/decode/branch sequencer with downstream handoff
// Runs FETCH/DECODE, executes BEQ/BNE/BLT/BGE, JAL and JALR, and hands every other opcode off.
module branch_control_unit (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] instr,
  input  logic        mem_ready,
  input  logic        ext_done,
  output logic        MemRead,
  output logic        IrWrite,
  output logic        PcWrite,
  output logic        PcWriteCond,
  output logic [1:0]  BranchType,
  output logic [1:0]  PcSource,
  output logic [1:0]  AluSrcA,
  output logic [1:0]  AluSrcB,
  output logic [1:0]  AluOp,
  output logic        AluOutWrite,
  output logic        RegWrite,
  output logic        MemToReg,
  output logic        ext_start,
  output logic        illegal
);

  localparam logic [2:0] S_FETCH    = 3'd0;
  localparam logic [2:0] S_DECODE   = 3'd1;
  localparam logic [2:0] S_BRANCH   = 3'd2;
  localparam logic [2:0] S_JAL      = 3'd3;
  localparam logic [2:0] S_JALR     = 3'd4;
  localparam logic [2:0] S_HANDOFF  = 3'd5;
  localparam logic [2:0] S_WAIT_EXT = 3'd6;
  localparam logic [2:0] S_ILLEGAL  = 3'd7;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  logic [2:0] state;
  logic [2:0] state_next;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       unused_instr_bits;

  assign opcode            = instr[6:0];
  assign funct3            = instr[14:12];
  assign unused_instr_bits = ^{instr[31:15], instr[11:7]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_FETCH;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = S_FETCH;
    case (state)
      S_FETCH:    state_next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (opcode == OP_BRANCH) begin
          // BLTU/BGEU (funct3[1] set) are not executed here
          state_next = funct3[1] ? S_ILLEGAL : S_BRANCH;
        end else if (opcode == OP_JAL) begin
          state_next = S_JAL;
        end else if (opcode == OP_JALR) begin
          state_next = S_JALR;
        end else begin
          state_next = S_HANDOFF;
        end
      end
      S_HANDOFF:  state_next = S_WAIT_EXT;
      S_WAIT_EXT: state_next = ext_done ? S_FETCH : S_WAIT_EXT;
      default:    state_next = S_FETCH;
    endcase
  end

  // Outputs are held at zero for as long as reset is asserted
  always_comb begin
    MemRead     = 1'b0;
    IrWrite     = 1'b0;
    PcWrite     = 1'b0;
    PcWriteCond = 1'b0;
    BranchType  = 2'd0;
    PcSource    = 2'd0;
    AluSrcA     = 2'd0;
    AluSrcB     = 2'd0;
    AluOp       = 2'd0;
    AluOutWrite = 1'b0;
    RegWrite    = 1'b0;
    MemToReg    = 1'b0;
    ext_start   = 1'b0;
    illegal     = 1'b0;
    if (reset_n) begin
      case (state)
        S_FETCH: begin
          MemRead = 1'b1;
          AluSrcB = 2'd1;
          IrWrite = mem_ready;
          PcWrite = mem_ready;
        end
        S_DECODE: begin
          AluSrcA     = 2'd2;
          AluSrcB     = 2'd2;
          AluOutWrite = 1'b1;
        end
        S_BRANCH: begin
          AluSrcA     = 2'd1;
          AluOp       = 2'd1;
          PcWriteCond = 1'b1;
          PcSource    = 2'd1;
          case (funct3)
            3'b001:  BranchType = 2'd1;
            3'b101:  BranchType = 2'd2;
            3'b100:  BranchType = 2'd3;
            default: BranchType = 2'd0;
          endcase
        end
        S_JAL: begin
          RegWrite = 1'b1;
          MemToReg = 1'b1;
          PcWrite  = 1'b1;
          PcSource = 2'd1;
        end
        S_JALR: begin
          AluSrcA  = 2'd1;
          AluSrcB  = 2'd2;
          PcWrite  = 1'b1;
          PcSource = 2'd2;
          RegWrite = 1'b1;
          MemToReg = 1'b1;
        end
        S_HANDOFF: ext_start = 1'b1;
        S_ILLEGAL: illegal   = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_branch_control_unit.sv
// tb/tb_branch_control_unit.sv - scoreboard bench for branch_control_unit
// Stimulus pushes per-cycle expected control vectors; a negedge monitor pops and compares.
module tb_branch_control_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] instr;
  logic        mem_ready;
  logic        ext_done;
  logic        MemRead, IrWrite, PcWrite, PcWriteCond;
  logic [1:0]  BranchType, PcSource, AluSrcA, AluSrcB, AluOp;
  logic        AluOutWrite, RegWrite, MemToReg, ext_start, illegal;

  typedef struct packed {
    logic       mem_read;
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] branch_type;
    logic [1:0] pc_source;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       alu_out_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic       ext_start;
    logic       illegal;
  } vec_t;

  vec_t act;
  vec_t exp_q[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   cyc        = 0;

  branch_control_unit dut (
    .clk(clk), .reset_n(reset_n), .instr(instr), .mem_ready(mem_ready), .ext_done(ext_done),
    .MemRead(MemRead), .IrWrite(IrWrite), .PcWrite(PcWrite), .PcWriteCond(PcWriteCond),
    .BranchType(BranchType), .PcSource(PcSource), .AluSrcA(AluSrcA), .AluSrcB(AluSrcB),
    .AluOp(AluOp), .AluOutWrite(AluOutWrite), .RegWrite(RegWrite), .MemToReg(MemToReg),
    .ext_start(ext_start), .illegal(illegal)
  );

  always #5 clk = ~clk;

  assign act = {MemRead, IrWrite, PcWrite, PcWriteCond, BranchType, PcSource, AluSrcA,
                AluSrcB, AluOp, AluOutWrite, RegWrite, MemToReg, ext_start, illegal};

  // Reference model: what the datapath must see in each phase of an instruction
  function automatic vec_t fetch_v(input logic ready);
    vec_t v = '0;
    v.mem_read  = 1'b1;
    v.alu_src_b = 2'd1;
    v.ir_write  = ready;
    v.pc_write  = ready;
    return v;
  endfunction

  function automatic vec_t decode_v();
    vec_t v = '0;
    v.alu_src_a     = 2'd2;
    v.alu_src_b     = 2'd2;
    v.alu_out_write = 1'b1;
    return v;
  endfunction

  function automatic vec_t exec_v(input logic [31:0] ins);
    vec_t v = '0;
    int   f3 = int'(ins[14:12]);
    int   bt_of[8] = '{0, 1, -1, -1, 3, 2, -1, -1};
    if (ins[6:0] == 7'h63) begin
      if (bt_of[f3] < 0) begin
        v.illegal = 1'b1;
      end else begin
        v.alu_src_a     = 2'd1;
        v.alu_op        = 2'd1;
        v.pc_write_cond = 1'b1;
        v.pc_source     = 2'd1;
        v.branch_type   = 2'(bt_of[f3]);
      end
    end else if (ins[6:0] == 7'h6f) begin
      v.reg_write  = 1'b1;
      v.mem_to_reg = 1'b1;
      v.pc_write   = 1'b1;
      v.pc_source  = 2'd1;
    end else if (ins[6:0] == 7'h67) begin
      v.alu_src_a  = 2'd1;
      v.alu_src_b  = 2'd2;
      v.pc_write   = 1'b1;
      v.pc_source  = 2'd2;
      v.reg_write  = 1'b1;
      v.mem_to_reg = 1'b1;
    end else begin
      v.ext_start = 1'b1;
    end
    return v;
  endfunction

  function automatic logic is_handoff(input logic [31:0] ins);
    return !(ins[6:0] inside {7'h63, 7'h6f, 7'h67});
  endfunction

  task automatic step(input logic rn, input logic mr, input logic ed, input logic [31:0] ins,
                      input vec_t e);
    @(posedge clk);
    #1;
    reset_n   = rn;
    mem_ready = mr;
    ext_done  = ed;
    instr     = ins;
    exp_q.push_back(e);
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // One instruction from FETCH back to the next FETCH; abort_wait resets inside WAIT_EXT
  task automatic run_instr(input logic [31:0] ins, input int stalls, input int lat,
                           input logic abort_wait);
    for (int i = 0; i < stalls; i++) step(1'b1, 1'b0, rb(), ins, fetch_v(1'b0));
    step(1'b1, 1'b1, rb(), ins, fetch_v(1'b1));
    step(1'b1, rb(), rb(), ins, decode_v());
    step(1'b1, rb(), rb(), ins, exec_v(ins));
    if (is_handoff(ins)) begin
      for (int i = 0; i < lat; i++) step(1'b1, rb(), 1'b0, ins, '0);
      if (abort_wait) begin
        step(1'b0, rb(), 1'b1, ins, '0);
        step(1'b0, rb(), 1'b1, ins, '0);
        // Late ext_done after reset must not advance out of FETCH
        step(1'b1, 1'b0, 1'b1, ins, fetch_v(1'b0));
      end else begin
        step(1'b1, rb(), 1'b1, ins, '0);
      end
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w = $urandom;
    logic [6:0]  op;
    case ($urandom_range(0, 3))
      0: w[6:0] = 7'h63;
      1: w[6:0] = 7'h6f;
      2: w[6:0] = 7'h67;
      default: begin
        op = 7'($urandom);
        while (op inside {7'h63, 7'h6f, 7'h67}) op = 7'($urandom);
        w[6:0] = op;
      end
    endcase
    return w;
  endfunction

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (exp_q.size() > 0) begin
      vec_t e;
      e = exp_q.pop_front();
      compared++;
      if (act !== e) begin
        mismatched++;
        $display("FAIL ctrl_vec cycle %0d instr=%08h: actual=%06h expected=%06h", cyc, instr,
                 act, e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] directed[8];
    directed = '{32'h00208463, 32'h00209463, 32'h0020C463, 32'h0020D463,
                 32'h010000EF, 32'h000280E7, 32'h0020E463, 32'h002081B3};
    reset_n   = 1'b0;
    instr     = 32'h0;
    mem_ready = 1'b0;
    ext_done  = 1'b0;
    step(1'b0, 1'b1, 1'b0, 32'h0, '0);
    step(1'b0, 1'b1, 1'b1, 32'h0, '0);
    foreach (directed[i]) run_instr(directed[i], 0, 5, 1'b0);
    run_instr(32'h00208463, 4, 0, 1'b0);
    run_instr(32'h002081B3, 1, 2, 1'b1);
    run_instr(32'h000280E7, 0, 0, 1'b0);
    run_instr(32'h002081B3, 0, 0, 1'b0);
    for (int n = 0; n < 80; n++) begin
      run_instr(rand_instr(), $urandom_range(0, 3), $urandom_range(0, 4),
                ($urandom_range(0, 9) == 0));
    end
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      compared++;
      mismatched++;
      $display("FAIL drain: actual=%0d pending expected=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
